wvb_reader: RTL and testbench

// - Readout stage downstream of the waveform buffer and its overflow controller.
// - Pops one event header from the header FIFO and streams that event's waveform

---
 rtl/wvb_reader.sv | 194 +++++++++++++++++++
 tb/tb_wvb_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wvb_reader.sv
`default_nettype none
// ============================================================================
// wvb_reader : pops one event header and streams the event's waveform words
//              with valid/ready through a 2-entry skid buffer.
// Optional feature macro: WVB_READER_CNT_EN adds the n_evts_read counter.
// Revision  : 1.0
// ============================================================================
module wvb_reader #(
    parameter int P_ADR_WIDTH  = 15,
    parameter int P_HDR_WIDTH  = 87,
    parameter int P_DATA_WIDTH = 22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
    output logic [P_DATA_WIDTH-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sof,
    output logic                    dout_eof,
    output logic                    wvb_rddone,
`ifdef WVB_READER_CNT_EN
    output logic [31:0]             n_evts_read,
`endif
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [P_ADR_WIDTH-1:0]  addr_q;
    logic [P_ADR_WIDTH:0]    rem_q;
    logic                    first_q;
    logic                    pend_q;
    logic                    pend_sof_q;
    logic                    pend_eof_q;
    logic [1:0]              cnt_q;
    logic [P_DATA_WIDTH-1:0] hd_data_q;
    logic                    hd_sof_q;
    logic                    hd_eof_q;
    logic [P_DATA_WIDTH-1:0] tl_data_q;
    logic                    tl_sof_q;
    logic                    tl_eof_q;
    logic                    rddone_q;
    logic                    busy_q;

    logic [P_ADR_WIDTH-1:0]  start_d;
    logic [P_ADR_WIDTH-1:0]  stop_d;
    logic [P_ADR_WIDTH:0]    len_d;
    logic                    pop;
    logic                    issue;
    logic                    hdr_unused;

    assign stop_d  = hdr_data[P_ADR_WIDTH-1:0];
    assign start_d = hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH];
    // Extra bit keeps a full-buffer event (stop == start-1) from reading as 0.
    assign len_d   = {1'b0, stop_d - start_d} + (P_ADR_WIDTH+1)'(1);
    assign hdr_unused = ^hdr_data[P_HDR_WIDTH-1:2*P_ADR_WIDTH];

    assign dout_valid = (cnt_q != 2'd0);
    assign pop        = dout_valid && dout_ready;
    // Counting the same-cycle pop keeps full rate with only two skid slots.
    assign issue      = (state_q == S_READ) &&
                        ((({1'b0, cnt_q} + {2'b00, pend_q}) - {2'b00, pop}) < 3'd2);

    assign hdr_rdreq   = rst_n && (state_q == S_IDLE) && !hdr_empty;
    assign wvb_rd_addr = addr_q;
    assign dout        = hd_data_q;
    assign dout_sof    = hd_sof_q && dout_valid;
    assign dout_eof    = hd_eof_q && dout_valid;
    assign wvb_rddone  = rddone_q;
    assign busy        = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_sof_q <= 1'b0;
            pend_eof_q <= 1'b0;
            cnt_q      <= 2'd0;
            hd_data_q  <= '0;
            hd_sof_q   <= 1'b0;
            hd_eof_q   <= 1'b0;
            tl_data_q  <= '0;
            tl_sof_q   <= 1'b0;
            tl_eof_q   <= 1'b0;
            rddone_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rddone_q <= 1'b0;
            pend_q   <= issue;
            if (issue) begin
                pend_sof_q <= first_q;
                pend_eof_q <= (rem_q == (P_ADR_WIDTH+1)'(1));
                first_q    <= 1'b0;
                addr_q     <= addr_q + P_ADR_WIDTH'(1);
                rem_q      <= rem_q - (P_ADR_WIDTH+1)'(1);
            end

            // Skid FIFO: head drives dout, tail holds the word behind it.
            case ({pop, pend_q})
                2'b01: begin
                    if (cnt_q == 2'd0) begin
                        hd_data_q <= wvb_rd_data;
                        hd_sof_q  <= pend_sof_q;
                        hd_eof_q  <= pend_eof_q;
                    end else begin
                        tl_data_q <= wvb_rd_data;
                        tl_sof_q  <= pend_sof_q;
                        tl_eof_q  <= pend_eof_q;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b10: begin
                    hd_data_q <= tl_data_q;
                    hd_sof_q  <= tl_sof_q;
                    hd_eof_q  <= tl_eof_q;
                    cnt_q     <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        hd_data_q <= wvb_rd_data;
                        hd_sof_q  <= pend_sof_q;
                        hd_eof_q  <= pend_eof_q;
                    end else begin
                        hd_data_q <= tl_data_q;
                        hd_sof_q  <= tl_sof_q;
                        hd_eof_q  <= tl_eof_q;
                        tl_data_q <= wvb_rd_data;
                        tl_sof_q  <= pend_sof_q;
                        tl_eof_q  <= pend_eof_q;
                    end
                end
                default: ;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (!hdr_empty) begin
                        addr_q  <= start_d;
                        rem_q   <= len_d;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue && (rem_q == (P_ADR_WIDTH+1)'(1))) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && hd_eof_q) begin
                        rddone_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef WVB_READER_CNT_EN
    logic [31:0] evt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_cnt_q <= 32'd0;
        end else if (rddone_q && (evt_cnt_q != 32'hFFFF_FFFF)) begin
            evt_cnt_q <= evt_cnt_q + 32'd1;
        end
    end

    assign n_evts_read = evt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wvb_reader.sv
`default_nettype none
// tb_wvb_reader : directed bench for wvb_reader built with a 4-bit address so
// wrap-around and full-buffer events stay short.
module tb_wvb_reader;

    localparam int AW = 4;
    localparam int HW = 87;
    localparam int DW = 22;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eof;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HW-1:0] hdr_data;
    logic          hdr_empty;
    logic          hdr_rdreq;
    logic [AW-1:0] wvb_rd_addr;
    logic [DW-1:0] wvb_rd_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_sof;
    logic          dout_eof;
    logic          wvb_rddone;
    logic          busy;
`ifdef WVB_READER_CNT_EN
    logic [31:0]   n_evts_read;
`endif

    wvb_reader #(
        .P_ADR_WIDTH (AW),
        .P_HDR_WIDTH (HW),
        .P_DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hdr_data   (hdr_data),
        .hdr_empty  (hdr_empty),
        .hdr_rdreq  (hdr_rdreq),
        .wvb_rd_addr(wvb_rd_addr),
        .wvb_rd_data(wvb_rd_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof),
        .wvb_rddone (wvb_rddone),
`ifdef WVB_READER_CNT_EN
        .n_evts_read(n_evts_read),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waveform buffer: registered read, contents are a fixed function of address.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return DW'(32'h2C000 + 32'(a) * 32'd37);
    endfunction

    always @(posedge clk) wvb_rd_data <= mem_val(wvb_rd_addr);

    logic bp_en = 1'b0;
    always @(posedge clk) begin
        #1;
        dout_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    word_t cap[$];
    int    cyc      = 0;
    int    done_cnt = 0;
    int    sof_cyc  = 0;
    int    eof_cyc  = 0;
    int    done_cyc = 0;
    logic  stall_q  = 1'b0;
    word_t stall_w  = '0;

    always @(negedge clk) begin
        cyc++;
        if (stall_q) begin
            check("stall_valid", 64'(dout_valid), 64'd1);
            check("stall_word", 64'({dout, dout_sof, dout_eof}), 64'(stall_w));
        end
        stall_q = dout_valid && !dout_ready;
        stall_w = {dout, dout_sof, dout_eof};
        if (dout_valid && dout_ready) begin
            cap.push_back(word_t'({dout, dout_sof, dout_eof}));
            if (dout_sof) sof_cyc = cyc;
            if (dout_eof) eof_cyc = cyc;
        end
        if (wvb_rddone) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hdr_empty) check("rdreq_while_empty", 64'(hdr_rdreq), 64'd0);
    end

    task automatic send_hdr(input logic [AW-1:0] start, input logic [AW-1:0] stop, input string tag);
        bit seen = 1'b0;
        @(posedge clk);
        #1;
        hdr_data  = {(HW-2*AW)'($urandom), start, stop};
        hdr_empty = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = hdr_rdreq;
        end
        check({tag, "_rdreq"}, 64'(seen), 64'd1);
        @(posedge clk);
        #1 hdr_empty = 1'b1;
    endtask

    task automatic run_event(input logic [AW-1:0] start, input logic [AW-1:0] stop,
                             input int exp_len, input bit bp, input bit chk_lat,
                             input string tag);
        int base;
        int d0;
        int n;
        logic [AW-1:0] a;
        base  = cap.size();
        d0    = done_cnt;
        bp_en = bp;
        send_hdr(start, stop, tag);
        if (chk_lat) begin
            @(negedge clk);
            check({tag, "_lat1"}, 64'(dout_valid), 64'd0);
            check({tag, "_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            check({tag, "_lat2"}, 64'(dout_valid), 64'd0);
            @(negedge clk);
            check({tag, "_lat3"}, 64'(dout_valid), 64'd1);
        end
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_count"}, 64'(cap.size() - base), 64'(exp_len));
        for (int i = 0; i < exp_len && (base + i) < cap.size(); i++) begin
            a = start + AW'(i);
            check({tag, "_data"}, 64'(cap[base+i].d), 64'(mem_val(a)));
            check({tag, "_sof"}, 64'(cap[base+i].sof), 64'(i == 0));
            check({tag, "_eof"}, 64'(cap[base+i].eof), 64'(i == exp_len - 1));
        end
        check({tag, "_done_lag"}, 64'(done_cyc - eof_cyc), 64'd1);
        if (!bp) check({tag, "_rate"}, 64'(eof_cyc - sof_cyc), 64'(exp_len - 1));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(wvb_rddone), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        bp_en = 1'b0;
    endtask

    initial begin
        int base;
        int d0;
        int n;
        rst_n     = 1'b0;
        hdr_empty = 1'b0;
        hdr_data  = {(HW-2*AW)'(0), 4'd3, 4'd4};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdreq", 64'(hdr_rdreq), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_sof_eof", 64'({dout_sof, dout_eof}), 64'd0);
        check("rst_rddone", 64'(wvb_rddone), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(wvb_rd_addr), 64'd0);
        hdr_empty = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_event(4'd10, 4'd13, 4, 1'b0, 1'b1, "single");
        run_event(4'd14, 4'd1, 4, 1'b0, 1'b0, "wrap");
        run_event(4'd5, 4'd5, 1, 1'b0, 1'b0, "one");
        run_event(4'd0, 4'd15, 16, 1'b0, 1'b0, "full");
        run_event(4'd7, 4'd6, 16, 1'b1, 1'b0, "bp");

        // Reset after the third word of an 8-word event.
        base = cap.size();
        d0   = done_cnt;
        send_hdr(4'd2, 4'd9, "mid");
        n = 0;
        while ((cap.size() - base) < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_progress", 64'(cap.size() - base >= 3), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_valid", 64'(dout_valid), 64'd0);
        check("mid_outs", 64'({dout, dout_sof, dout_eof, wvb_rddone, busy, wvb_rd_addr}), 64'd0);
        repeat (10) @(negedge clk);
        check("mid_no_done", 64'(done_cnt - d0), 64'd0);
        run_event(4'd3, 4'd6, 4, 1'b0, 1'b0, "post_rst");

`ifdef WVB_READER_CNT_EN
        run_event(4'd1, 4'd2, 2, 1'b0, 1'b0, "cnt_a");
        run_event(4'd8, 4'd8, 1, 1'b0, 1'b0, "cnt_b");
        check("cnt_three", 64'(n_evts_read), 64'd3);
        @(negedge clk);
        force dut.evt_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.evt_cnt_q;
        run_event(4'd4, 4'd6, 3, 1'b0, 1'b0, "cnt_sat");
        check("cnt_saturate", 64'(n_evts_read), 64'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
